// File: rtl/arch_int_delayed_update_tracker_pkg.sv
// ---------------------------------------------------------------------------
// arch_int_delayed_pkg
// Shared types and constants for the integer delayed-update event tracker.
//   delayed_evt_t : one resolved deferred write {addr, data, nack}
//   NUM_INT_REGS  : width of the pending scoreboard (one bit per x-register)
//   DEFAULT_DEPTH : default event FIFO depth
// ---------------------------------------------------------------------------
package arch_int_delayed_pkg;

    localparam int NUM_INT_REGS  = 32;
    localparam int DEFAULT_DEPTH = 4;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
        logic        nack;
    } delayed_evt_t;

endpackage

// File: rtl/arch_int_delayed_update_tracker_if.sv
// ---------------------------------------------------------------------------
// arch_int_delayed_update_tracker_if
// Bundles the writeback/commit request side and the difftest probe side of
// the tracker.
//   master : core side (drives mark/cmpl/kill/coreid, observes the rest)
//   slave  : tracker side
// Signals: coreid, mark_valid/addr, cmpl_valid/addr/data, kill_valid/addr,
//          cmpl_ready, out_valid/address/data/nack/coreid/index, pending, err
// ---------------------------------------------------------------------------
interface arch_int_delayed_update_tracker_if;
    import arch_int_delayed_pkg::*;

    logic [7:0]              coreid;
    logic                    mark_valid;
    logic [4:0]              mark_addr;
    logic                    cmpl_valid;
    logic [4:0]              cmpl_addr;
    logic [63:0]             cmpl_data;
    logic                    kill_valid;
    logic [4:0]              kill_addr;
    logic                    cmpl_ready;
    logic                    out_valid;
    logic [4:0]              out_address;
    logic [63:0]             out_data;
    logic                    out_nack;
    logic [7:0]              out_coreid;
    logic [7:0]              out_index;
    logic [NUM_INT_REGS-1:0] pending;
    logic                    err;

    modport master (
        output coreid, mark_valid, mark_addr, cmpl_valid, cmpl_addr, cmpl_data,
               kill_valid, kill_addr,
        input  cmpl_ready, out_valid, out_address, out_data, out_nack,
               out_coreid, out_index, pending, err
    );

    modport slave (
        input  coreid, mark_valid, mark_addr, cmpl_valid, cmpl_addr, cmpl_data,
               kill_valid, kill_addr,
        output cmpl_ready, out_valid, out_address, out_data, out_nack,
               out_coreid, out_index, pending, err
    );

endinterface

// File: rtl/arch_int_delayed_update_tracker_fifo.sv
// ---------------------------------------------------------------------------
// delayed_update_fifo
// Dual-push / single-pop FIFO of delayed_evt_t.
//   clock, reset     : clock, synchronous active-high reset (pointers only)
//   push0_i, evt0_i  : first event written this cycle
//   push1_i, evt1_i  : second event, only meaningful together with push0_i
//   pop_i            : remove the head entry (ignored when empty)
//   head_o, empty_o  : current head entry and empty flag
//   free_o           : number of free entries
// ---------------------------------------------------------------------------
module delayed_update_fifo
    import arch_int_delayed_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push0_i,
    input  delayed_evt_t               evt0_i,
    input  logic                       push1_i,
    input  delayed_evt_t               evt1_i,
    input  logic                       pop_i,
    output delayed_evt_t               head_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     free_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    delayed_evt_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_pop;

    // DEPTH is a power of two, so plain pointer overflow wraps modulo DEPTH.
    always_comb begin
        do_pop = pop_i && (cnt_q != '0);
        wptr_d = wptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rptr_d = rptr_q + PTR_W'(do_pop);
        cnt_d  = cnt_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage holds data only; validity is tracked by the pointers above.
    always_ff @(posedge clock) begin
        if (push0_i) mem_q[wptr_q]               <= evt0_i;
        if (push1_i) mem_q[wptr_q + PTR_W'(1)]   <= evt1_i;
    end

    assign head_o  = mem_q[rptr_q];
    assign empty_o = (cnt_q == '0);
    assign free_o  = CNT_W'(DEPTH) - cnt_q;

endmodule

// File: rtl/arch_int_delayed_update_tracker.sv
// ---------------------------------------------------------------------------
// arch_int_delayed_update_tracker
// Producer side of the difftest integer delayed-update stream. Keeps a
// scoreboard of x-registers whose commit-time writeback is deferred, matches
// late completions and kills against it, queues one event per resolution and
// drains the queue at one event per cycle into the probe.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : mark/cmpl/kill requests, cmpl_ready, probe outputs,
//                  pending scoreboard, sticky err
// Optional: `define DELAYED_UPDATE_CHECK_EN to build the protocol checker
// driving err; otherwise err is tied low.
// ---------------------------------------------------------------------------
module arch_int_delayed_update_tracker
    import arch_int_delayed_pkg::*;
#(
    parameter int         DEPTH      = DEFAULT_DEPTH,
    parameter logic [7:0] PORT_INDEX = 8'd0
) (
    input  logic                           clock,
    input  logic                           reset,
    arch_int_delayed_update_tracker_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_INT_REGS-1:0] pending_q, pending_d;
    logic                    out_valid_q, out_valid_d;
    delayed_evt_t            out_evt_q, out_evt_d;

    logic                    mark_ok, cmpl_req, kill_req;
    logic                    cmpl_match, kill_match, same_reg;
    logic                    push_c, push_k, push0, push1, cmpl_ready;
    delayed_evt_t            cmpl_evt, kill_evt, evt0, evt1, head;
    logic                    empty;
    logic [CNT_W-1:0]        free;

    always_comb begin
        // x0 is hard-wired zero and never tracked.
        mark_ok  = bus.mark_valid && (bus.mark_addr != '0);
        cmpl_req = bus.cmpl_valid && (bus.cmpl_addr != '0);
        kill_req = bus.kill_valid && (bus.kill_addr != '0);

        // Two free slots are required so a completion and kill can always
        // both land in the same cycle.
        cmpl_ready = (free >= CNT_W'(2));

        // A mark in the same cycle counts as pending (bypass).
        cmpl_match = pending_q[bus.cmpl_addr] || (mark_ok && (bus.mark_addr == bus.cmpl_addr));
        kill_match = pending_q[bus.kill_addr] || (mark_ok && (bus.mark_addr == bus.kill_addr));
        same_reg   = cmpl_req && kill_req && (bus.cmpl_addr == bus.kill_addr);

        // On a same-register collision the kill wins and the completion is dropped.
        push_c = cmpl_ready && cmpl_req && cmpl_match && !same_reg;
        push_k = cmpl_ready && kill_req && kill_match;

        cmpl_evt.addr = bus.cmpl_addr;
        cmpl_evt.data = bus.cmpl_data;
        cmpl_evt.nack = 1'b0;
        kill_evt.addr = bus.kill_addr;
        kill_evt.data = '0;
        kill_evt.nack = 1'b1;

        // Completion always takes the first slot so it drains before the kill.
        evt0  = push_c ? cmpl_evt : kill_evt;
        evt1  = kill_evt;
        push0 = push_c || push_k;
        push1 = push_c && push_k;

        // Set before clear: a resolution in the marking cycle leaves the bit 0.
        pending_d = pending_q;
        if (mark_ok) pending_d[bus.mark_addr] = 1'b1;
        if (push_c)  pending_d[bus.cmpl_addr] = 1'b0;
        if (push_k)  pending_d[bus.kill_addr] = 1'b0;

        // No backpressure on the probe: the output register is consumed every
        // cycle, so it reloads from the head whenever the FIFO holds an event.
        out_valid_d = !empty;
        out_evt_d   = empty ? out_evt_q : head;
    end

    delayed_update_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push0_i (push0),
        .evt0_i  (evt0),
        .push1_i (push1),
        .evt1_i  (evt1),
        .pop_i   (!empty),
        .head_o  (head),
        .empty_o (empty),
        .free_o  (free)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_evt_q   <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_evt_q   <= out_evt_d;
        end
    end

`ifdef DELAYED_UPDATE_CHECK_EN
    logic err_q, err_d, proto_err;

    always_comb begin
        proto_err = (mark_ok && pending_q[bus.mark_addr])
                 || (cmpl_ready && cmpl_req && !cmpl_match)
                 || (cmpl_ready && kill_req && !kill_match)
                 || (!cmpl_ready && (cmpl_req || kill_req));
        err_d = err_q || proto_err;
    end

    always_ff @(posedge clock) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.cmpl_ready  = cmpl_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_address = out_evt_q.addr;
    assign bus.out_data    = out_evt_q.data;
    assign bus.out_nack    = out_evt_q.nack;
    assign bus.out_coreid  = bus.coreid;
    assign bus.out_index   = PORT_INDEX;
    assign bus.pending     = pending_q;

endmodule

// File: tb/tb_arch_int_delayed_update_tracker.sv
// ---------------------------------------------------------------------------
// tb_arch_int_delayed_update_tracker
// Directed, table-driven bench for arch_int_delayed_update_tracker with
// hand-written sequences for back-pressure, reset mid-stream and the
// sticky error flag.
// ---------------------------------------------------------------------------
module tb_arch_int_delayed_update_tracker;
    import arch_int_delayed_pkg::*;

`ifdef DELAYED_UPDATE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    arch_int_delayed_update_tracker_if bus ();

    arch_int_delayed_update_tracker #(
        .DEPTH      (4),
        .PORT_INDEX (8'd0)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    typedef struct {
        logic        mv;  logic [4:0] ma;
        logic        cv;  logic [4:0] ca; logic [63:0] cd;
        logic        kv;  logic [4:0] ka;
        logic [31:0] pend; logic rdy; logic ov;
        logic [4:0]  oa;  logic [63:0] od; logic on; logic err;
    } vec_t;

    int errors = 0;
    int checks = 0;

    delayed_evt_t rx_q[$];
    logic         collect = 1'b0;

    always @(negedge clk) begin
        if (collect && bus.out_valid)
            rx_q.push_back('{addr: bus.out_address, data: bus.out_data, nack: bus.out_nack});
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic mv, input logic [4:0] ma,
                         input logic cv, input logic [4:0] ca, input logic [63:0] cd,
                         input logic kv, input logic [4:0] ka);
        bus.mark_valid = mv; bus.mark_addr = ma;
        bus.cmpl_valid = cv; bus.cmpl_addr = ca; bus.cmpl_data = cd;
        bus.kill_valid = kv; bus.kill_addr = ka;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.cmpl_ready && n < 20) begin
            tick();
            n++;
        end
        chk("wait_ready", bus.cmpl_ready, 1);
    endtask

    function automatic vec_t mk(logic mv, logic [4:0] ma, logic cv, logic [4:0] ca,
                                logic [63:0] cd, logic kv, logic [4:0] ka,
                                logic [31:0] pend, logic ov, logic [4:0] oa,
                                logic [63:0] od, logic on, logic err);
        vec_t v;
        v.mv = mv; v.ma = ma; v.cv = cv; v.ca = ca; v.cd = cd; v.kv = kv; v.ka = ka;
        v.pend = pend; v.rdy = 1'b1; v.ov = ov; v.oa = oa; v.od = od; v.on = on; v.err = err;
        return v;
    endfunction

    initial begin
        vec_t         tbl [21];
        delayed_evt_t exp_q[$];
        logic         saw_stall;
        logic [63:0]  pd [3];

        // Outputs after the edge that applies each row.
        tbl[0]  = mk(1,5,  0,0,0,                     0,0,  32'h20,  0,0,0,0,0);
        tbl[1]  = mk(0,0,  0,0,0,                     0,0,  32'h20,  0,0,0,0,0);
        tbl[2]  = mk(0,0,  1,5,64'hDEAD_BEEF,         0,0,  32'h0,   0,0,0,0,0);
        tbl[3]  = mk(0,0,  0,0,0,                     0,0,  32'h0,   1,5,64'hDEAD_BEEF,0,0);
        tbl[4]  = mk(1,7,  1,7,64'h77,                0,0,  32'h0,   0,0,0,0,0);
        tbl[5]  = mk(1,3,  0,0,0,                     0,0,  32'h8,   1,7,64'h77,0,0);
        tbl[6]  = mk(1,9,  0,0,0,                     0,0,  32'h208, 0,0,0,0,0);
        tbl[7]  = mk(0,0,  1,3,64'h1234_5678_9ABC_DEF0,1,9, 32'h0,   0,0,0,0,0);
        tbl[8]  = mk(0,0,  0,0,0,                     0,0,  32'h0,   1,3,64'h1234_5678_9ABC_DEF0,0,0);
        tbl[9]  = mk(0,0,  0,0,0,                     0,0,  32'h0,   1,9,0,1,0);
        tbl[10] = mk(0,0,  0,0,0,                     0,0,  32'h0,   0,0,0,0,0);
        tbl[11] = mk(1,0,  1,0,64'h55,                0,0,  32'h0,   0,0,0,0,0);
        tbl[12] = mk(0,0,  0,0,0,                     0,0,  32'h0,   0,0,0,0,0);
        tbl[13] = mk(1,4,  0,0,0,                     1,4,  32'h0,   0,0,0,0,0);
        tbl[14] = mk(0,0,  0,0,0,                     0,0,  32'h0,   1,4,0,1,0);
        tbl[15] = mk(1,10, 0,0,0,                     0,0,  32'h400, 0,0,0,0,0);
        tbl[16] = mk(0,0,  1,10,64'hAA,               1,10, 32'h0,   0,0,0,0,0);
        tbl[17] = mk(0,0,  0,0,0,                     0,0,  32'h0,   1,10,0,1,0);
        tbl[18] = mk(0,0,  0,0,0,                     0,0,  32'h0,   0,0,0,0,0);
        tbl[19] = mk(0,0,  1,12,64'h99,               0,0,  32'h0,   0,0,0,0,1);
        tbl[20] = mk(0,0,  0,0,0,                     0,0,  32'h0,   0,0,0,0,1);

        bus.coreid = 8'h3C;
        idle();
        tick();
        tick();
        rst = 1'b0;

        chk("rst_pending",   bus.pending, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_addr",  bus.out_address, 0);
        chk("rst_out_data",  bus.out_data, 0);
        chk("rst_out_nack",  bus.out_nack, 0);
        chk("rst_err",       bus.err, 0);
        chk("rst_ready",     bus.cmpl_ready, 1);
        chk("out_coreid",    bus.out_coreid, 8'h3C);
        chk("out_index",     bus.out_index, 0);

        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].mv, tbl[i].ma, tbl[i].cv, tbl[i].ca, tbl[i].cd, tbl[i].kv, tbl[i].ka);
            tick();
            chk($sformatf("v%0d_pending", i), bus.pending, tbl[i].pend);
            chk($sformatf("v%0d_ready", i),   bus.cmpl_ready, tbl[i].rdy);
            chk($sformatf("v%0d_valid", i),   bus.out_valid, tbl[i].ov);
            chk($sformatf("v%0d_err", i),     bus.err, tbl[i].err & CHK);
            if (tbl[i].ov) begin
                chk($sformatf("v%0d_addr", i), bus.out_address, tbl[i].oa);
                chk($sformatf("v%0d_data", i), bus.out_data, tbl[i].od);
                chk($sformatf("v%0d_nack", i), bus.out_nack, tbl[i].on);
            end
        end
        idle();

        // Sticky error clears only on reset; mark of a pending register.
        do_reset();
        chk("err_cleared", bus.err, 0);
        drive(1, 2, 0, 0, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 0, 0, 0); tick();
        chk("remark_pending", bus.pending, 32'h4);
        chk("remark_err",     bus.err, CHK);
        idle();

        // Back-pressure: three dual pushes fill the FIFO to 3 entries.
        do_reset();
        for (int r = 1; r <= 6; r++) begin
            drive(1, 5'(r), 0, 0, 0, 0, 0);
            tick();
        end
        idle();
        chk("bp_pending", bus.pending, 32'h7E);
        pd[0] = 64'h1111; pd[1] = 64'h3333; pd[2] = 64'h5555;
        exp_q = {};
        for (int p = 0; p < 3; p++) begin
            exp_q.push_back('{addr: 5'(2*p+1), data: pd[p], nack: 1'b0});
            exp_q.push_back('{addr: 5'(2*p+2), data: 64'h0, nack: 1'b1});
        end
        rx_q = {};
        collect = 1'b1;
        saw_stall = 1'b0;
        for (int p = 0; p < 3; p++) begin
            wait_ready();
            drive(0, 0, 1, 5'(2*p+1), pd[p], 1, 5'(2*p+2));
            tick();
            idle();
            if (!bus.cmpl_ready) saw_stall = 1'b1;
            if (p == 1) chk("bp_ready_drop", bus.cmpl_ready, 0);
        end
        repeat (10) tick();
        collect = 1'b0;
        chk("bp_stalled",   saw_stall, 1);
        chk("bp_count",     rx_q.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < rx_q.size()) begin
                chk($sformatf("bp_ev%0d_addr", k), rx_q[k].addr, exp_q[k].addr);
                chk($sformatf("bp_ev%0d_data", k), rx_q[k].data, exp_q[k].data);
                chk($sformatf("bp_ev%0d_nack", k), rx_q[k].nack, exp_q[k].nack);
            end
        end
        chk("bp_pending_end", bus.pending, 0);
        chk("bp_err",         bus.err, 0);

        // Reset mid-stream discards queued events and the scoreboard.
        do_reset();
        drive(1, 1, 0, 0, 0, 0, 0); tick();
        drive(1, 2, 0, 0, 0, 0, 0); tick();
        drive(1, 3, 0, 0, 0, 0, 0); tick();
        drive(1, 8, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 64'hA1, 1, 2); tick();
        drive(0, 0, 1, 3, 64'hA3, 0, 0); tick();
        chk("mid_pending", bus.pending, 32'h100);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid",   bus.out_valid, 0);
        chk("mid_rst_pending", bus.pending, 0);
        chk("mid_rst_ready",   bus.cmpl_ready, 1);
        rx_q = {};
        collect = 1'b1;
        repeat (6) tick();
        drive(1, 0, 1, 0, 64'h42, 0, 0); tick();
        idle();
        repeat (4) tick();
        collect = 1'b0;
        chk("mid_no_stale", rx_q.size(), 0);
        chk("x0_pending",   bus.pending, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
